sdram_init_seq: RTL and testbench

Parametrised SDRAM power-up initialisation sequencer. It drives CKE, the 4-bit command bus, the address and the bank address until the mode register is loaded. It then holds init_done high and hands the bus to the refresh/access arbiter. Successor to the fixed single-shot init counter, with these additions:
- power-up wait, all timings, refresh count and mode-register fields are parameters;
- init_done is sticky rather than a one-cycle pulse;
- the arbiter can request re-initialisation without going through reset.

---
 rtl/sdram_init_seq.sv | 197 +++++++++++++++++++
 tb/tb_sdram_init_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sdram_init_seq.sv
// SDRAM power-up initialisation sequencer: NOP wait, PRECHARGE-ALL, NUM_REF auto-refreshes,
// LOAD MODE, then a sticky init_done. Re-initialisation from DONE skips the power-up wait.
module sdram_init_seq #(
  parameter int unsigned ASIZE      = 13,
  parameter int unsigned BSIZE      = 2,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned T_PWR      = 20000,
  parameter int unsigned T_RP       = 2,
  parameter int unsigned T_RFC      = 7,
  parameter int unsigned T_MRD      = 2,
  parameter int unsigned NUM_REF    = 2,
  parameter int unsigned CAS_LAT    = 3,
  parameter int unsigned BURST_LEN  = 1,
  parameter int unsigned BURST_TYPE = 0,
  parameter int unsigned WB_MODE    = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             reinit_req,
  output logic             cke,
  output logic [3:0]       command,
  output logic [ASIZE-1:0] saddr,
  output logic [BSIZE-1:0] sba,
  output logic             init_busy,
  output logic             init_done
);

  localparam int unsigned REF_W = 4;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MSET = 4'b0000;

  localparam logic [CNT_W-1:0] T_PWR_C   = CNT_W'(T_PWR);
  localparam logic [CNT_W-1:0] T_RP_C    = CNT_W'(T_RP);
  localparam logic [CNT_W-1:0] T_RFC_C   = CNT_W'(T_RFC);
  localparam logic [CNT_W-1:0] T_MRD_C   = CNT_W'(T_MRD);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [REF_W-1:0] NUM_REF_C = REF_W'(NUM_REF);

  localparam logic [2:0] BL_CODE = (BURST_LEN == 1) ? 3'b000 :
                                   (BURST_LEN == 2) ? 3'b001 :
                                   (BURST_LEN == 4) ? 3'b010 :
                                   (BURST_LEN == 8) ? 3'b011 : 3'b111;

  function automatic logic [ASIZE-1:0] mode_word_f();
    logic [ASIZE-1:0] w;
    w      = '0;
    w[9]   = (WB_MODE != 0);
    w[6:4] = 3'(CAS_LAT);
    w[3]   = (BURST_TYPE != 0);
    w[2:0] = BL_CODE;
    return w;
  endfunction

  function automatic logic [ASIZE-1:0] pre_word_f();
    logic [ASIZE-1:0] w;
    w     = '0;
    w[10] = 1'b1;
    return w;
  endfunction

  localparam logic [ASIZE-1:0] MODE_WORD = mode_word_f();
  localparam logic [ASIZE-1:0] PRE_WORD  = pre_word_f();

  typedef enum logic [2:0] {
    PWR_WAIT,
    PRE,
    RP_WAIT,
    REF,
    RFC_WAIT,
    MRS,
    MRD_WAIT,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REF_W-1:0]   ref_q, ref_d;
  logic               reinit_q, reinit_d;
  logic               cke_q, cke_d;
  logic [3:0]         cmd_q, cmd_d;
  logic [ASIZE-1:0]   addr_q, addr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= PWR_WAIT;
      cnt_q    <= '0;
      ref_q    <= '0;
      reinit_q <= 1'b0;
      cke_q    <= 1'b0;
      cmd_q    <= CMD_NOP;
      addr_q   <= '0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ref_q    <= ref_d;
      reinit_q <= reinit_d;
      cke_q    <= cke_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // cnt_q counts edges since the last command; each command state entry reloads it to 1
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_ONE;
    ref_d    = ref_q;
    reinit_d = reinit_req && (state_q == DONE);
    cke_d    = 1'b1;
    cmd_d    = CMD_NOP;
    addr_d   = '0;
    busy_d   = 1'b1;
    done_d   = 1'b0;

    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == T_PWR_C) begin
          state_d = PRE;
          cmd_d   = CMD_PRE;
          addr_d  = PRE_WORD;
          cnt_d   = CNT_ONE;
          ref_d   = '0;
        end
      end
      PRE, RP_WAIT: begin
        if (cnt_q == T_RP_C) begin
          state_d = REF;
          cmd_d   = CMD_AREF;
          cnt_d   = CNT_ONE;
          ref_d   = ref_q + REF_W'(1);
        end else begin
          state_d = RP_WAIT;
        end
      end
      REF, RFC_WAIT: begin
        if (cnt_q == T_RFC_C) begin
          cnt_d = CNT_ONE;
          if (ref_q == NUM_REF_C) begin
            state_d = MRS;
            cmd_d   = CMD_MSET;
            addr_d  = MODE_WORD;
          end else begin
            state_d = REF;
            cmd_d   = CMD_AREF;
            ref_d   = ref_q + REF_W'(1);
          end
        end else begin
          state_d = RFC_WAIT;
        end
      end
      MRS, MRD_WAIT: begin
        if (cnt_q == T_MRD_C) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = MRD_WAIT;
        end
      end
      DONE: begin
        cnt_d = cnt_q;
        if (reinit_q) begin
          state_d = PRE;
          cmd_d   = CMD_PRE;
          addr_d  = PRE_WORD;
          cnt_d   = CNT_ONE;
          ref_d   = '0;
        end else begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = PWR_WAIT;
        cnt_d   = '0;
        ref_d   = '0;
      end
    endcase
  end

  assign cke       = cke_q;
  assign command   = cmd_q;
  assign saddr     = addr_q;
  assign sba       = '0;
  assign init_busy = busy_q;
  assign init_done = done_q;

endmodule

// File: tb/tb_sdram_init_seq.sv
// Directed bench for sdram_init_seq: three parameter sets checked edge by edge against
// hand-derived command timelines, plus re-init and mid-sequence reset.
module tb_sdram_init_seq;

  localparam int T_RP  = 2;
  localparam int T_RFC = 7;
  localparam int T_MRD = 2;
  localparam int TP    = 10;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] MSET = 4'b0000;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic reinit_nom = 1'b0;

  logic        cke_a, cke_b, cke_c;
  logic [3:0]  cmd_a, cmd_b, cmd_c;
  logic [12:0] addr_a, addr_b, addr_c;
  logic [1:0]  sba_a, sba_b, sba_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  // nominal: CL3, BL4, sequential, burst writes -> 0x032
  sdram_init_seq #(.T_PWR(10), .T_RP(2), .T_RFC(7), .T_MRD(2), .NUM_REF(2),
                   .CAS_LAT(3), .BURST_LEN(4), .BURST_TYPE(0), .WB_MODE(0)) u_nom (
    .CLK(CLK), .RST(RST), .reinit_req(reinit_nom), .cke(cke_a), .command(cmd_a),
    .saddr(addr_a), .sba(sba_a), .init_busy(busy_a), .init_done(done_a));

  // eight refreshes: CL3, BL8, sequential, burst writes -> 0x033
  sdram_init_seq #(.T_PWR(10), .T_RP(2), .T_RFC(7), .T_MRD(2), .NUM_REF(8),
                   .CAS_LAT(3), .BURST_LEN(8), .BURST_TYPE(0), .WB_MODE(0)) u_ref8 (
    .CLK(CLK), .RST(RST), .reinit_req(1'b0), .cke(cke_b), .command(cmd_b),
    .saddr(addr_b), .sba(sba_b), .init_busy(busy_b), .init_done(done_b));

  // CL2, full page, interleaved, single writes -> 0x22F
  sdram_init_seq #(.T_PWR(10), .T_RP(2), .T_RFC(7), .T_MRD(2), .NUM_REF(2),
                   .CAS_LAT(2), .BURST_LEN(0), .BURST_TYPE(1), .WB_MODE(1)) u_mode (
    .CLK(CLK), .RST(RST), .reinit_req(1'b0), .cke(cke_c), .command(cmd_c),
    .saddr(addr_c), .sba(sba_c), .init_busy(busy_c), .init_done(done_c));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_cmd_f(int e, int base, int nref);
    if (e == base) return PRE;
    for (int i = 0; i < nref; i++)
      if (e == base + T_RP + i * T_RFC) return AREF;
    if (e == base + T_RP + nref * T_RFC) return MSET;
    return NOP;
  endfunction

  function automatic logic [12:0] exp_addr_f(int e, int base, int nref, logic [12:0] mode);
    logic [3:0] c;
    c = exp_cmd_f(e, base, nref);
    if (c == PRE)  return 13'h400;
    if (c == MSET) return mode;
    return 13'h000;
  endfunction

  function automatic logic exp_done_f(int e, int base, int nref);
    return e >= base + T_RP + nref * T_RFC + T_MRD;
  endfunction

  task automatic check_reset(input string ph);
    check_eq({ph, " rst cke"},  {31'd0, cke_a}, 32'd0);
    check_eq({ph, " rst cmd"},  {28'd0, cmd_a}, {28'd0, NOP});
    check_eq({ph, " rst addr"}, {19'd0, addr_a}, 32'd0);
    check_eq({ph, " rst sba"},  {30'd0, sba_a}, 32'd0);
    check_eq({ph, " rst busy"}, {31'd0, busy_a}, 32'd1);
    check_eq({ph, " rst done"}, {31'd0, done_a}, 32'd0);
    check_eq({ph, " rst cmd8"}, {28'd0, cmd_b}, {28'd0, NOP});
    check_eq({ph, " rst cke8"}, {31'd0, cke_b}, 32'd0);
    check_eq({ph, " rst cmdm"}, {28'd0, cmd_c}, {28'd0, NOP});
    check_eq({ph, " rst busym"}, {31'd0, busy_c}, 32'd1);
  endtask

  // base_nom is the PRE edge of the nominal instance; done_nom is supplied by the caller
  task automatic check_edge(input int e, input int base_nom, input logic done_nom);
    string s;
    s = $sformatf("e%0d", e);
    check_eq({"nom cmd ", s},  {28'd0, cmd_a},  {28'd0, exp_cmd_f(e, base_nom, 2)});
    check_eq({"nom addr ", s}, {19'd0, addr_a}, {19'd0, exp_addr_f(e, base_nom, 2, 13'h032)});
    check_eq({"nom cke ", s},  {31'd0, cke_a},  32'd1);
    check_eq({"nom sba ", s},  {30'd0, sba_a},  32'd0);
    check_eq({"nom done ", s}, {31'd0, done_a}, {31'd0, done_nom});
    check_eq({"nom busy ", s}, {31'd0, busy_a}, {31'd0, !done_nom});
    check_eq({"ref8 cmd ", s},  {28'd0, cmd_b},  {28'd0, exp_cmd_f(e, TP, 8)});
    check_eq({"ref8 addr ", s}, {19'd0, addr_b}, {19'd0, exp_addr_f(e, TP, 8, 13'h033)});
    check_eq({"ref8 done ", s}, {31'd0, done_b}, {31'd0, exp_done_f(e, TP, 8)});
    check_eq({"ref8 cke ", s},  {31'd0, cke_b},  32'd1);
    check_eq({"mode cmd ", s},  {28'd0, cmd_c},  {28'd0, exp_cmd_f(e, TP, 2)});
    check_eq({"mode addr ", s}, {19'd0, addr_c}, {19'd0, exp_addr_f(e, TP, 2, 13'h22F)});
    check_eq({"mode done ", s}, {31'd0, done_c}, {31'd0, exp_done_f(e, TP, 2)});
    check_eq({"mode busy ", s}, {31'd0, busy_c}, {31'd0, !exp_done_f(e, TP, 2)});
  endtask

  initial begin
    int  base;
    logic dn;

    // phase 1: nominal run, ignored re-init at 15, accepted re-init at 40
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_reset("p1");
    @(negedge CLK);
    RST = 1'b0;
    for (int e = 0; e <= 76; e++) begin
      @(posedge CLK);
      #1;
      base = (e >= 41) ? 41 : TP;
      dn   = (e < 41) ? exp_done_f(e, TP, 2) : exp_done_f(e, 41, 2);
      check_edge(e, base, dn);
      reinit_nom = (e == 14) || (e == 39);
    end

    // phase 2: reset asserted just after edge 20, then a full replay from a new edge 0
    @(negedge CLK);
    RST = 1'b1;
    #1;
    RST = 1'b0;
    for (int e = 0; e <= 20; e++) begin
      @(posedge CLK);
      #1;
      check_edge(e, TP, exp_done_f(e, TP, 2));
    end
    RST = 1'b1;
    #1;
    check_reset("p2 async");
    repeat (2) @(posedge CLK);
    #1;
    check_reset("p2 hold");
    @(negedge CLK);
    RST = 1'b0;
    for (int e = 0; e <= 35; e++) begin
      @(posedge CLK);
      #1;
      check_edge(e, TP, exp_done_f(e, TP, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
